uart_alu_ctrl: RTL

Command sequencer between the UART receiver, the ALU and the UART transmitter. Collects three received bytes (operand A, operand B, opcode) and drives them as registered ALU inputs. Launches the ALU result on the transmitter and waits for transmit completion before accepting the next command. An inter-byte timeout, counted in baud ticks, discards partial commands.

---
 rtl/uart_alu_pkg.sv | 15 +
 rtl/uart_alu_ctrl_tick_timeout.sv | 32 +++
 rtl/uart_alu_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared state encoding and defaults for the UART/ALU command sequencer
package uart_alu_pkg;

  localparam int NB_STATE              = 3;
  localparam int DEFAULT_TIMEOUT_TICKS = 640;

  typedef enum logic [NB_STATE-1:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

endpackage

// File: rtl/uart_alu_ctrl_tick_timeout.sv
// rtl/uart_alu_ctrl_tick_timeout.sv - inter-byte tick counter with clear, enable and expire pulse
module tick_timeout #(
  parameter int TICKS = 640
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int NB_CNT = $clog2(TICKS);

  logic [NB_CNT-1:0] r_count;
  logic              w_last;

  assign w_last   = (r_count == NB_CNT'(TICKS - 1));
  // a clear in the same cycle (accepted byte) wins over the expiring tick
  assign o_expire = i_enable && i_tick && w_last && !i_clear;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_enable && i_tick) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - collects A/B/opcode bytes, drives the ALU, launches the result on the transmitter
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_timeout,
  output logic               o_overrun
);

  state_t r_state;
  state_t w_next;

  logic               w_accept;
  logic               w_overrun;
  logic               w_expire;
  logic               w_enable;
  logic               w_clear;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;
  logic               r_timeout;
  logic               r_overrun;

  assign w_enable = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_clear  = w_accept || (r_state == ST_WAIT_A);

  tick_timeout #(
    .TICKS(TIMEOUT_TICKS)
  ) u_tick_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_tick  (i_tick),
    .i_clear (w_clear),
    .i_enable(w_enable),
    .o_expire(w_expire)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_WAIT_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_overrun = 1'b0;
    case (r_state)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          w_accept = 1'b1;
          w_next   = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          w_accept = 1'b1;
          w_next   = ST_WAIT_OP;
        end else if (w_expire) begin
          w_next = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          w_accept = 1'b1;
          w_next   = ST_SEND;
        end else if (w_expire) begin
          w_next = ST_WAIT_A;
        end
      end
      ST_SEND: begin
        w_overrun = i_rx_done;
        w_next    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        w_overrun = i_rx_done;
        if (i_tx_done) begin
          w_next = ST_WAIT_A;
        end
      end
      default: w_next = ST_WAIT_A;
    endcase
  end

  // i_alu_result has settled from the operand registers by the SEND cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_accept && (r_state == ST_WAIT_A))  r_alu_a  <= i_rx_data;
      if (w_accept && (r_state == ST_WAIT_B))  r_alu_b  <= i_rx_data;
      if (w_accept && (r_state == ST_WAIT_OP)) r_alu_op <= i_rx_data[NB_OP-1:0];
      if (r_state == ST_SEND)                  r_tx_data <= i_alu_result;
      r_tx_start <= (r_state == ST_SEND);
      r_timeout  <= w_expire;
      r_overrun  <= w_overrun;
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_timeout  = r_timeout;
  assign o_overrun  = r_overrun;

endmodule
